vga_tile_renderer: RTL and testbench

//  Display-side counterpart of the game controller's tile interface. Generates
//  640x480@60 VGA timing from vgaclk and drives the tile coordinates pixelH/pixelV.

---
 rtl/vga_tile_renderer.sv | 152 +++++++++++++++
 tb/tb_vga_tile_renderer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/vga_tile_renderer.sv
`timescale 1ns/1ps
// vga_tile_renderer
//   Generates 640x480@60 VGA timing and renders a 256x256 tiled picture window
//   (16x16 tiles of 16x16 pixels) from an external picture ROM.
//   The tile under the beam is reported on pixelH/pixelV. The game controller
//   answers in the same cycle with addr/inv/isarrow. addr is registered onto
//   rom_addr, and the ROM answer is composed into an RGB332 pixel together with
//   syncs that carry the same pipeline latency (ROM_LAT+2 cycles).
//
// Ports
//   vgaclk      pixel clock
//   reset       synchronous, active-high
//   pixelH/V    tile column/row under the beam (0 outside the picture window)
//   addr        picture index for the current tile
//   inv         invert the colour of the current tile
//   isarrow     current tile holds the cursor (draws a border)
//   rom_addr    registered picture-ROM address
//   rom_data    ROM data, valid ROM_LAT cycles after rom_addr
//   hsync/vsync active-low syncs
//   rgb         RGB332 pixel
//   frame_tick  one-cycle pulse at the start of vertical blank
//
// ROM_LAT must lie in 1..3.
module vga_tile_renderer #(
    parameter int H_VIS   = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_VIS   = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33,
    parameter int X_OFF   = 192,
    parameter int Y_OFF   = 112,
    parameter int ROM_LAT = 1,
    parameter logic [7:0] BG_COLOR    = 8'h00,
    parameter logic [7:0] ARROW_COLOR = 8'hE0
) (
    input  logic       vgaclk,
    input  logic       reset,
    output logic [3:0] pixelH,
    output logic [3:0] pixelV,
    input  logic [7:0] addr,
    input  logic       inv,
    input  logic       isarrow,
    output logic [7:0] rom_addr,
    input  logic [7:0] rom_data,
    output logic       hsync,
    output logic       vsync,
    output logic [7:0] rgb,
    output logic       frame_tick
);

    localparam logic [9:0] H_LAST = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_VISL = 10'(H_VIS);
    localparam logic [9:0] V_VISL = 10'(V_VIS);
    localparam logic [9:0] HS_LO  = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_HI  = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] VS_LO  = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_HI  = 10'(V_VIS + V_FP + V_SYNC);
    localparam logic [9:0] X_LO   = 10'(X_OFF);
    localparam logic [9:0] X_HI   = 10'(X_OFF + 256);
    localparam logic [9:0] Y_LO   = 10'(Y_OFF);
    localparam logic [9:0] Y_HI   = 10'(Y_OFF + 256);
    localparam logic [7:0] X_LO8  = 8'(X_OFF);
    localparam logic [7:0] Y_LO8  = 8'(Y_OFF);

    // Side-band word: {inv, isarrow, in_pic, visible, border, hs, vs}.
    // The blank word keeps syncs inactive so a flush never emits a sync pulse.
    localparam logic [6:0] BLANK = 7'b000_0011;

    logic [9:0] hcnt, vcnt;
    logic [7:0] dx, dy;
    logic       in_pic, visible, border, hs, vs;
    logic [6:0] s1;
    logic [6:0] dly [ROM_LAT];
    logic [6:0] sb;

    // Beam counters
    always_ff @(posedge vgaclk) begin
        if (reset) begin
            hcnt <= 10'd0;
            vcnt <= 10'd0;
        end else if (hcnt == H_LAST) begin
            hcnt <= 10'd0;
            vcnt <= (vcnt == V_LAST) ? 10'd0 : vcnt + 10'd1;
        end else begin
            hcnt <= hcnt + 10'd1;
        end
    end

    // Stage 0: window offsets are only meaningful while in_pic, so an 8-bit
    // difference is enough.
    assign dx      = hcnt[7:0] - X_LO8;
    assign dy      = vcnt[7:0] - Y_LO8;
    assign in_pic  = (hcnt >= X_LO) && (hcnt < X_HI) && (vcnt >= Y_LO) && (vcnt < Y_HI);
    assign visible = (hcnt < H_VISL) && (vcnt < V_VISL);
    assign border  = (dx[3:0] == 4'h0) || (dx[3:0] == 4'hF) ||
                     (dy[3:0] == 4'h0) || (dy[3:0] == 4'hF);
    assign hs      = !((hcnt >= HS_LO) && (hcnt < HS_HI));
    assign vs      = !((vcnt >= VS_LO) && (vcnt < VS_HI));
    assign pixelH  = in_pic ? dx[7:4] : 4'd0;
    assign pixelV  = in_pic ? dy[7:4] : 4'd0;

    // Stage 1: ROM address plus the side-band that must follow it
    always_ff @(posedge vgaclk) begin
        if (reset) begin
            rom_addr <= 8'd0;
            s1       <= BLANK;
        end else begin
            rom_addr <= addr;
            s1       <= {inv, isarrow, in_pic, visible, border, hs, vs};
        end
    end

    // Side-band delay matching the ROM read latency
    always_ff @(posedge vgaclk) begin
        if (reset) begin
            for (int i = 0; i < ROM_LAT; i++) dly[i] <= BLANK;
        end else begin
            dly[0] <= s1;
            for (int i = 1; i < ROM_LAT; i++) dly[i] <= dly[i-1];
        end
    end

    assign sb = dly[ROM_LAT-1];

    // Output register; the cursor border wins over inversion.
    always_ff @(posedge vgaclk) begin
        if (reset) begin
            rgb   <= 8'd0;
            hsync <= 1'b1;
            vsync <= 1'b1;
        end else begin
            hsync <= sb[1];
            vsync <= sb[0];
            if (!sb[3])             rgb <= 8'd0;
            else if (!sb[4])        rgb <= BG_COLOR;
            else if (sb[5] && sb[2]) rgb <= ARROW_COLOR;
            else if (sb[6])         rgb <= ~rom_data;
            else                    rgb <= rom_data;
        end
    end

    // Frame tick is taken straight from the counters, not the pixel pipeline.
    always_ff @(posedge vgaclk) begin
        if (reset) frame_tick <= 1'b0;
        else       frame_tick <= (hcnt == 10'd0) && (vcnt == V_VISL);
    end

endmodule

// File: tb/tb_vga_tile_renderer.sv
`timescale 1ns/1ps
// Bench for vga_tile_renderer. Horizontal timing and X window are the real
// values; the frame is shortened vertically so two frames fit in a short run.
module tb_vga_tile_renderer;

    localparam int HT    = 800;
    localparam int VV    = 24;
    localparam int VT    = 30;
    localparam int XO    = 192;
    localparam int YO    = 4;
    localparam int FRAME = HT * VT;
    localparam logic [7:0] BG = 8'h25;
    localparam logic [7:0] AR = 8'hE0;

    logic       vgaclk = 1'b0;
    logic       reset  = 1'b1;
    logic [3:0] pixelH, pixelV;
    logic [7:0] addr, rom_addr, rom_data, rgb;
    logic [7:0] amask = 8'h00;
    logic       inv = 1'b0, isarrow = 1'b0;
    logic       hsync, vsync, frame_tick;

    int k, n_cmp, n_fail, hs_low, vs_low, ticks;
    bit tick_prev;
    logic [9:0] exp_q[$];

    vga_tile_renderer #(
        .V_VIS(VV), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .Y_OFF(YO), .BG_COLOR(BG), .ARROW_COLOR(AR)
    ) dut (
        .vgaclk(vgaclk), .reset(reset),
        .pixelH(pixelH), .pixelV(pixelV),
        .addr(addr), .inv(inv), .isarrow(isarrow),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .hsync(hsync), .vsync(vsync), .rgb(rgb), .frame_tick(frame_tick)
    );

    always #20 vgaclk = ~vgaclk;

    // Picture ROM: one-cycle latency, contents equal the address
    always @(posedge vgaclk) rom_data <= rom_addr;

    // Controller stub: tile index {row,col}, optionally scrambled
    assign addr = {pixelV, pixelH} ^ amask;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s k=%0d got=%0h exp=%0h", tag, k, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_rgb(int h, int v, bit iv, bit ar, logic [7:0] am);
        int x, y;
        logic [7:0] d;
        x = h - XO;
        y = v - YO;
        if (!(h < 640 && v < VV)) return 8'h00;
        if (!(h >= XO && h < XO + 256 && v >= YO && v < YO + 256)) return BG;
        if (ar && (x % 16 == 0 || x % 16 == 15 || y % 16 == 0 || y % 16 == 15)) return AR;
        d = 8'((y / 16) * 16 + (x / 16)) ^ am;
        return iv ? ~d : d;
    endfunction

    task automatic model_reset();
        k = 0;
        exp_q.delete();
        for (int i = 0; i < 3; i++) exp_q.push_back({8'h00, 1'b1, 1'b1});
        tick_prev = 1'b0;
        hs_low = 0;
        vs_low = 0;
        ticks  = 0;
    endtask

    // One beam position: drive inputs, check everything, record the expectation.
    task automatic step();
        int h, v, x, y;
        bit inpic;
        logic [9:0] e;
        h = k % HT;
        v = (k / HT) % VT;
        inv     = ($urandom % 2) == 1;
        isarrow = ($urandom % 4) == 0;
        amask   = (($urandom % 4) == 0) ? 8'($urandom) : 8'h00;
        #1;
        x = h - XO;
        y = v - YO;
        inpic = h >= XO && h < XO + 256 && v >= YO && v < YO + 256;
        chk("pixelH", 32'(pixelH), inpic ? 32'(x / 16) : 32'd0);
        chk("pixelV", 32'(pixelV), inpic ? 32'(y / 16) : 32'd0);
        e = exp_q.pop_front();
        chk("rgb", 32'(rgb), 32'(e[9:2]));
        chk("hsync", 32'(hsync), 32'(e[1]));
        chk("vsync", 32'(vsync), 32'(e[0]));
        chk("frame_tick", 32'(frame_tick), 32'(tick_prev));
        if (k >= 3 && k < FRAME + 3) begin
            if (!hsync) hs_low++;
            if (!vsync) vs_low++;
        end
        if (k >= 1 && k < FRAME + 3 && frame_tick) ticks++;
        if (k == FRAME + 3) begin
            chk("hsync_low_per_frame", 32'(hs_low), 32'(96 * VT));
            chk("vsync_low_per_frame", 32'(vs_low), 32'(2 * HT));
            chk("ticks_per_frame", 32'(ticks), 32'd1);
        end
        exp_q.push_back({ref_rgb(h, v, inv, isarrow, amask),
                         !(h >= 656 && h < 752),
                         !(v >= VV + 2 && v < VV + 4)});
        tick_prev = (h == 0 && v == VV);
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        k      = 0;
        // Outputs while reset is held
        for (int i = 0; i < 4; i++) begin
            @(posedge vgaclk);
            #1;
            chk("rst_rgb", 32'(rgb), 32'd0);
            chk("rst_hsync", 32'(hsync), 32'd1);
            chk("rst_vsync", 32'(vsync), 32'd1);
            chk("rst_tick", 32'(frame_tick), 32'd0);
            chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        end
        reset = 1'b0;
        model_reset();
        step();
        // One full frame, then into the next to hcnt=700, vcnt=10
        while (k < FRAME + 10 * HT + 700) begin
            @(posedge vgaclk);
            #1;
            k++;
            step();
        end
        // Single-cycle reset mid-frame
        reset = 1'b1;
        @(posedge vgaclk);
        #1;
        reset = 1'b0;
        model_reset();
        step();
        while (k < FRAME + 2 * HT) begin
            @(posedge vgaclk);
            #1;
            k++;
            step();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
